// File: rtl/fifo_serializer.sv
// fifo_serializer
// Pops one word at a time from an upstream FIFO and shifts it out serially,
// MSB first, holding each bit for BIT_DIV clocks, then idles high for
// GAP_CYCLES clocks before looking at the FIFO again.
//
// Ports
//   clk         : single clock, all state updates on the rising edge
//   reset       : synchronous, active-high reset
//   emptyreg    : upstream FIFO empty flag (only looked at in IDLE)
//   dout        : upstream FIFO read data, valid the cycle after rd_enb
//   rd_enb      : one-cycle pop request per word
//   ser_out     : serial data, idle level 1
//   ser_valid   : high while ser_out carries a data bit
//   frame_start : high for the first clock of the first (MSB) bit only
//   busy        : high in every state except IDLE
//   word_count  : words fully transmitted, modulo 256
module fifo_serializer #(
  parameter int WIDTH      = 16,
  parameter int BIT_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             emptyreg,
  input  logic [WIDTH-1:0] dout,
  output logic             rd_enb,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       word_count
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       cnt;       // bit divider in SHIFT, gap timer in GAP
  logic             bit_done;
  logic             last_bit;
  logic             gap_done;

  always_comb begin
    bit_done = (cnt == 8'(BIT_DIV - 1));
    last_bit = bit_done && (bit_cnt == BW'(WIDTH - 1));
    gap_done = (cnt == 8'(GAP_CYCLES - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and Moore outputs
  always_comb begin
    next_state  = state;
    rd_enb      = 1'b0;
    ser_out     = 1'b1;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!emptyreg) next_state = REQ;
      end
      REQ: begin
        rd_enb     = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        next_state = SHIFT;
      end
      SHIFT: begin
        ser_out     = shreg[WIDTH-1];
        ser_valid   = 1'b1;
        frame_start = (bit_cnt == '0) && (cnt == '0);
        if (last_bit) next_state = GAP;
      end
      GAP: begin
        if (gap_done) next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: shift register, counters, transmitted-word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
      word_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= dout;
          bit_cnt <= '0;
          cnt     <= '0;
        end
        SHIFT: begin
          if (bit_done) begin
            // cnt is left at zero on the last bit so GAP starts timing from 0
            cnt   <= '0;
            shreg <= shreg << 1;
            if (last_bit) begin
              bit_cnt    <= '0;
              word_count <= word_count + 8'd1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_done) cnt <= '0;
          else          cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer
// Directed bench for fifo_serializer: one instance at default parameters and
// one with BIT_DIV=1. Inputs change and outputs are sampled on the falling
// edge; the design updates on the rising edge.
module tb_fifo_serializer;

  localparam int W  = 16;
  localparam int BD = 4;
  localparam int GC = 2;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, emptyreg;
  logic [W-1:0] dout;
  logic         rd_enb, ser_out, ser_valid, frame_start, busy;
  logic [7:0]   word_count;

  logic         reset2, emptyreg2;
  logic [W-1:0] dout2;
  logic         rd_enb2, ser_out2, ser_valid2, frame_start2, busy2;
  logic [7:0]   word_count2;

  fifo_serializer #(.WIDTH(W), .BIT_DIV(BD), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .emptyreg(emptyreg), .dout(dout),
    .rd_enb(rd_enb), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .busy(busy), .word_count(word_count)
  );

  fifo_serializer #(.WIDTH(W), .BIT_DIV(1), .GAP_CYCLES(GC)) dut2 (
    .clk(clk), .reset(reset2), .emptyreg(emptyreg2), .dout(dout2),
    .rd_enb(rd_enb2), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .frame_start(frame_start2), .busy(busy2), .word_count(word_count2)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned t_rd     = 0;
  logic [7:0]  exp_wc   = '0;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starting from an IDLE falling edge: drop emptyreg, serve the pop, and
  // follow the word through SHIFT and GAP back into IDLE.
  task automatic send_word(input logic [W-1:0] word, input bit keep_low);
    int unsigned waited = 0;
    bit          seen   = 0;
    int          bit_err = 0, val_err = 0, fs_err = 0, oth_err = 0, gap_err = 0;
    emptyreg = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      waited++;
      if (rd_enb === 1'b1) seen = 1;
    end
    chk("rd_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("rd_latency", 32'(waited), 32'd1);
    t_rd = cyc;
    chk("req_busy", 32'(busy), 32'd1);
    if (!keep_low) emptyreg = 1'b1;
    dout = word;
    tick();  // LOAD
    chk("load_outputs", 32'({rd_enb, ser_valid, ser_out, busy}), 32'b0011);
    tick();  // first SHIFT cycle; dout captured already
    dout = ~word;
    for (int i = 0; i < W * BD; i++) begin
      if (i > 0) tick();
      if (!keep_low) emptyreg = (i % 2 == 1);
      if (ser_out !== word[W-1-i/BD]) bit_err++;
      if (ser_valid !== 1'b1) val_err++;
      if (frame_start !== (i == 0)) fs_err++;
      if (rd_enb !== 1'b0 || busy !== 1'b1) oth_err++;
    end
    emptyreg = keep_low ? 1'b0 : 1'b1;
    chk("shift_bits", 32'(bit_err), 32'd0);
    chk("shift_valid", 32'(val_err), 32'd0);
    chk("frame_start", 32'(fs_err), 32'd0);
    chk("shift_rd_busy", 32'(oth_err), 32'd0);
    exp_wc = exp_wc + 8'd1;
    for (int g = 0; g < GC; g++) begin
      tick();
      if ({ser_out, ser_valid, busy, rd_enb} !== 4'b1010) gap_err++;
      if (g == 0) chk("word_count", 32'(word_count), 32'(exp_wc));
    end
    chk("gap", 32'(gap_err), 32'd0);
    tick();
    chk("idle_after_gap", 32'({busy, ser_out, rd_enb}), 32'b010);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    emptyreg = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({rd_enb, ser_out, ser_valid, frame_start, busy}), 32'b01000);
    chk("reset_wc", 32'(word_count), 32'd0);
    reset  = 1'b0;
    exp_wc = '0;
  endtask

  initial begin
    int          hits;
    int          so_err;
    int          bz_err;
    bit          seen;
    int unsigned t1;
    int          nval;
    int          split;
    int          idle_err;
    logic        prev;
    logic [W-1:0] bits2;

    reset     = 1'b1;
    emptyreg  = 1'b1;
    dout      = '0;
    reset2    = 1'b1;
    emptyreg2 = 1'b1;
    dout2     = '0;
    tick();
    tick();
    chk("reset_outputs", 32'({rd_enb, ser_out, ser_valid, frame_start, busy}), 32'b01000);
    chk("reset_wc", 32'(word_count), 32'd0);
    reset  = 1'b0;
    reset2 = 1'b0;

    // FIFO stays empty: nothing may happen
    hits = 0; so_err = 0; bz_err = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rd_enb !== 1'b0) hits++;
      if (ser_out !== 1'b1) so_err++;
      if (busy !== 1'b0) bz_err++;
    end
    chk("empty_no_pop", 32'(hits), 32'd0);
    chk("empty_ser_high", 32'(so_err), 32'd0);
    chk("empty_not_busy", 32'(bz_err), 32'd0);

    // Reset during bit 7 of 0xA5A5
    emptyreg = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (rd_enb === 1'b1) seen = 1;
    end
    chk("abort_rd_seen", 32'(seen), 32'd1);
    emptyreg = 1'b1;
    dout = 16'hA5A5;
    tick();               // LOAD
    tick();               // SHIFT cycle 0
    dout = '0;
    repeat (33) tick();   // second cycle of bit index 7
    chk("abort_mid_valid", 32'(ser_valid), 32'd1);
    chk("abort_mid_bit", 32'(ser_out), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_outputs", 32'({ser_out, ser_valid, busy}), 32'b100);
    chk("abort_wc", 32'(word_count), 32'd0);
    reset = 1'b0;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rd_enb !== 1'b0 || busy !== 1'b0) hits++;
    end
    chk("abort_no_resend", 32'(hits), 32'd0);

    // Single word after the aborted one
    send_word(16'hB94E, 1'b0);
    chk("single_wc", 32'(word_count), 32'd1);
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_enb !== 1'b0) hits++;
    end
    chk("single_one_pop", 32'(hits), 32'd0);

    // Back-to-back words with emptyreg held low
    do_reset();
    send_word(16'hFFFF, 1'b1);
    t1 = t_rd;
    send_word(16'h0001, 1'b0);
    chk("pulse_spacing", 32'(t_rd - t1), 32'd69);
    chk("b2b_wc", 32'(word_count), 32'd2);

    // 257 words: counter wraps to 1
    do_reset();
    for (int n = 0; n < 257; n++)
      send_word(16'(n * 40503 + 7), n != 256);
    chk("wrap_wc", 32'(word_count), 32'd1);

    // BIT_DIV=1 instance, word 0x8001
    emptyreg2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (rd_enb2 === 1'b1) seen = 1;
    end
    chk("bd1_rd_seen", 32'(seen), 32'd1);
    emptyreg2 = 1'b1;
    dout2 = 16'h8001;
    nval = 0; split = 0; idle_err = 0; prev = 1'b0; bits2 = '0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (c == 1) dout2 = 16'h7FFE;
      if (ser_valid2 === 1'b1) begin
        if (nval > 0 && !prev) split++;
        bits2 = {bits2[W-2:0], ser_out2};
        nval++;
      end else if (ser_out2 !== 1'b1) begin
        idle_err++;
      end
      prev = ser_valid2;
    end
    chk("bd1_valid_cycles", 32'(nval), 32'd16);
    chk("bd1_contiguous", 32'(split), 32'd0);
    chk("bd1_bits", 32'(bits2), 32'h8001);
    chk("bd1_idle_high", 32'(idle_err), 32'd0);
    chk("bd1_wc", 32'(word_count2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001: Parameter WIDTH, default 16, FIFO word width in bits.
REQ-002: Parameter BIT_DIV, default 4, clock cycles per serial bit (legal 1..255).
REQ-003: Parameter GAP_CYCLES, default 2, idle-high cycles after each word (legal 1..255).
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: emptyreg  input  1  upstream FIFO empty flag.
REQ-007: dout  input  WIDTH  upstream FIFO read data, valid the cycle after rd_enb is high.
REQ-008: rd_enb  output  1  FIFO pop request, one-cycle pulse per word.
REQ-009: ser_out  output  1  serial data, MSB first, idle level 1.
REQ-010: ser_valid  output  1  high while ser_out carries a data bit.
REQ-011: frame_start  output  1  high for the first clock cycle of bit WIDTH-1 only.
REQ-012: busy  output  1  high in every state except IDLE.
REQ-013: word_count  output  8  count of words fully transmitted, modulo 256.

Function
REQ-014: The block SHALL implement a registered Moore FSM with states IDLE, REQ, LOAD, SHIFT, GAP.
REQ-015: IDLE: if emptyreg==0 at the edge, next state REQ; otherwise remain in IDLE.
REQ-016: REQ: rd_enb=1 for exactly this one cycle; next state LOAD unconditionally.
REQ-017: LOAD: capture dout into a WIDTH-bit shift register at the closing edge; clear bit and divider counters; next state SHIFT.
REQ-018: SHIFT: ser_out = shift register MSB, ser_valid=1; each bit held exactly BIT_DIV cycles, then shift left by one.
REQ-019: SHIFT exits to GAP after WIDTH bits; total SHIFT duration is exactly WIDTH*BIT_DIV cycles.
REQ-020: word_count SHALL increment by 1 on the SHIFT->GAP transition and wrap 255->0.
REQ-021: GAP: ser_out=1, ser_valid=0 for exactly GAP_CYCLES cycles; next state IDLE.
REQ-022: Latency: with emptyreg low, rd_enb rises 1 cycle after the sampling edge, and the first data bit appears 2 cycles after rd_enb rises.
REQ-023: Minimum word period SHALL be 3 + WIDTH*BIT_DIV + GAP_CYCLES cycles (69 at defaults).
REQ-024: rd_enb SHALL never be asserted outside REQ; in particular, no pop occurs while emptyreg==1 is sampled in IDLE.
REQ-025: emptyreg changes during REQ, LOAD, SHIFT or GAP SHALL be ignored.
REQ-026: dout SHALL be sampled only in LOAD; changes at any other time do not affect transmission.
REQ-027: When BIT_DIV==1, one bit SHALL be emitted per cycle with no idle cycles inside the word.

Reset
REQ-028: While reset is high at an edge: state=IDLE, rd_enb=0, ser_out=1, ser_valid=0, frame_start=0, busy=0, word_count=0, and shift register and counters cleared.
REQ-029: Reset asserted mid-word SHALL abort the word; the popped word is discarded without retransmission and word_count is not incremented.
REQ-030: After reset deasserts, the first possible rd_enb SHALL occur no earlier than 1 cycle after the first IDLE edge that samples emptyreg==0.

Verification
REQ-031: Hold emptyreg=1 for 100 cycles after reset -> rd_enb never high, ser_out=1, busy=0.
REQ-032: Single word 0xB94E, defaults -> one rd_enb pulse; ser_out bits 1011100101001110, each held 4 cycles; frame_start for 1 cycle; word_count=1.
REQ-033: emptyreg low continuously, words 0xFFFF then 0x0001 -> two rd_enb pulses exactly 69 cycles apart; GAP high for 2 cycles between words; word_count=2.
REQ-034: Reset pulsed during bit 7 of 0xA5A5 -> next cycle ser_out=1, ser_valid=0, busy=0, word_count unchanged at 0; a new word sent after reset transmits cleanly.
REQ-035: Send 257 words -> word_count reads 1 (wrap-around verified).
REQ-036: BIT_DIV=1, word 0x8001 -> ser_valid high for exactly 16 consecutive cycles; ser_out is 1, fourteen 0s, then 1.
